// File: rtl/iob_cache_line_fill_if.sv
// IOb request/response bus. The fill engine uses it on both sides: line-wide toward the cache
// and word-wide toward back-end memory.
interface iob_cache_line_fill_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic                avalid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                ready;

  modport master (output avalid, addr, wdata, wstrb, input  rdata, rvalid, ready);
  modport slave  (input  avalid, addr, wdata, wstrb, output rdata, rvalid, ready);
endinterface

// File: rtl/iob_cache_line_fill.sv
// Line refill / write-back engine: splits one line request into BLKSZ back-end word transactions.
// Define IOB_CACHE_LINE_FILL_PIPELINE_EN to let refills keep up to BLKSZ reads outstanding.
module iob_cache_line_fill #(
  parameter int BUF_ADDR_W    = 28,
  parameter int FE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  iob_cache_line_fill_if.slave  buf_iob,
  iob_cache_line_fill_if.master be_iob
);
  localparam int BLKSZ     = 1 << WORD_OFFSET_W;
  localparam int LINE_W    = FE_DATA_W * BLKSZ;
  localparam int NBYTES    = FE_DATA_W / 8;
  localparam int BE_ADDR_W = BUF_ADDR_W + WORD_OFFSET_W;
  localparam int CNT_W     = WORD_OFFSET_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                  state_q;
  logic [BUF_ADDR_W-1:0]   line_q;
  logic [LINE_W-1:0]       buf_q;
  logic [LINE_W/8-1:0]     strb_q;
  logic [CNT_W-1:0]        wcnt_q, rcnt_q;
  logic [LINE_W-1:0]       rdata_q;
  logic                    rvalid_q, ready_q;
  logic                    avalid_q;
  logic [BE_ADDR_W-1:0]    addr_q;
  logic [FE_DATA_W-1:0]    wdata_q;
  logic [NBYTES-1:0]       wstrb_q;

  logic [CNT_W-1:0]         wfirst_d, wnext_d, wcnt_inc, rcnt_inc;
  logic [WORD_OFFSET_W-1:0] wi_first, wi_next;
  logic [LINE_W-1:0]        fill_d;

  // Lowest word index >= from with a non-zero strobe slice; BLKSZ when none is left.
  function automatic logic [CNT_W-1:0] next_word(input logic [CNT_W-1:0] from,
                                                 input logic [LINE_W/8-1:0] strb);
    logic [CNT_W-1:0] idx;
    idx = CNT_W'(BLKSZ);
    for (int i = BLKSZ-1; i >= 0; i--)
      if (CNT_W'(i) >= from && |strb[i*NBYTES +: NBYTES]) idx = CNT_W'(i);
    return idx;
  endfunction

  assign wcnt_inc = wcnt_q + 1'b1;
  assign rcnt_inc = rcnt_q + 1'b1;
  assign wfirst_d = next_word('0, buf_iob.wstrb);
  assign wnext_d  = next_word(wcnt_inc, strb_q);
  assign wi_first = wfirst_d[WORD_OFFSET_W-1:0];
  assign wi_next  = wnext_d[WORD_OFFSET_W-1:0];

  // Line buffer with the incoming read word merged in, so the last word reaches rdata_o directly.
  always_comb begin
    fill_d = buf_q;
    fill_d[rcnt_q[WORD_OFFSET_W-1:0]*FE_DATA_W +: FE_DATA_W] = be_iob.rdata;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      line_q   <= '0;
      buf_q    <= '0;
      strb_q   <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: if (buf_iob.avalid) begin
          line_q   <= buf_iob.addr;
          buf_q    <= buf_iob.wdata;
          strb_q   <= buf_iob.wstrb;
          rcnt_q   <= '0;
          ready_q  <= 1'b0;
          avalid_q <= 1'b1;
          if (|buf_iob.wstrb) begin
            state_q <= WRITE;
            wcnt_q  <= wfirst_d;
            addr_q  <= {buf_iob.addr, wi_first};
            wdata_q <= buf_iob.wdata[wi_first*FE_DATA_W +: FE_DATA_W];
            wstrb_q <= buf_iob.wstrb[wi_first*NBYTES +: NBYTES];
          end else begin
            state_q <= READ;
            wcnt_q  <= '0;
            addr_q  <= {buf_iob.addr, {WORD_OFFSET_W{1'b0}}};
            wdata_q <= '0;
            wstrb_q <= '0;
          end
        end
        // avalid_q is always high here: the first word was chosen at accept time.
        WRITE: if (be_iob.ready) begin
          wcnt_q <= wnext_d;
          if (wnext_d == CNT_W'(BLKSZ)) begin
            state_q  <= IDLE;
            avalid_q <= 1'b0;
            wstrb_q  <= '0;
            ready_q  <= 1'b1;
          end else begin
            addr_q  <= {line_q, wi_next};
            wdata_q <= buf_q[wi_next*FE_DATA_W +: FE_DATA_W];
            wstrb_q <= strb_q[wi_next*NBYTES +: NBYTES];
          end
        end
        READ: begin
          if (avalid_q && be_iob.ready) begin
            wcnt_q <= wcnt_inc;
`ifdef IOB_CACHE_LINE_FILL_PIPELINE_EN
            if (wcnt_inc == CNT_W'(BLKSZ)) avalid_q <= 1'b0;
            else                           addr_q   <= {line_q, wcnt_inc[WORD_OFFSET_W-1:0]};
`else
            avalid_q <= 1'b0;
`endif
          end
          if (be_iob.rvalid) begin
            buf_q  <= fill_d;
            rcnt_q <= rcnt_inc;
            if (rcnt_inc == CNT_W'(BLKSZ)) begin
              state_q  <= DONE;
              avalid_q <= 1'b0;
              rvalid_q <= 1'b1;
              rdata_q  <= fill_d;
            end
`ifdef IOB_CACHE_LINE_FILL_PIPELINE_EN
`else
            else begin
              avalid_q <= 1'b1;
              addr_q   <= {line_q, rcnt_inc[WORD_OFFSET_W-1:0]};
            end
`endif
          end
        end
        DONE: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_iob.rdata  = rdata_q;
  assign buf_iob.rvalid = rvalid_q;
  assign buf_iob.ready  = ready_q;
  assign be_iob.avalid  = avalid_q;
  assign be_iob.addr    = addr_q;
  assign be_iob.wdata   = wdata_q;
  assign be_iob.wstrb   = wstrb_q;
endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Directed bench for iob_cache_line_fill: write-backs, refills, back-end stall and mid-transfer reset.
module tb_iob_cache_line_fill;
  localparam int AW = 28, DW = 32, WO = 2, LW = 128, BEAW = 30;

  logic clk = 1'b0, cke, arst_n;
  iob_cache_line_fill_if #(.ADDR_W(AW),   .DATA_W(LW)) buf_if();
  iob_cache_line_fill_if #(.ADDR_W(BEAW), .DATA_W(DW)) be_if();

  iob_cache_line_fill #(.BUF_ADDR_W(AW), .FE_DATA_W(DW), .WORD_OFFSET_W(WO)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .buf_iob(buf_if), .be_iob(be_if));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Back-end memory: answers reads lat cycles after accept with 0xA0+word; logs every transaction.
  int lat = 2;
  int due_q[$];  logic [DW-1:0] dat_q[$];
  int rd_cyc[$]; logic [BEAW-1:0] rd_addr[$];
  int wr_cyc[$]; logic [BEAW-1:0] wr_addr[$]; logic [DW-1:0] wr_data[$]; logic [3:0] wr_strb[$];
  int rv_cyc[$]; logic [LW-1:0] rv_data[$];

  always @(negedge clk) begin
    be_if.rvalid = 1'b0;
    be_if.rdata  = '0;
    if (!arst_n) begin
      due_q.delete(); dat_q.delete();
    end else begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        be_if.rvalid = 1'b1;
        be_if.rdata  = dat_q.pop_front();
        due_q.delete(0);
      end
      if (be_if.avalid && be_if.ready) begin
        if (be_if.wstrb == 4'h0) begin
          due_q.push_back(cyc + lat);
          dat_q.push_back(32'hA0 + {30'd0, be_if.addr[1:0]});
          rd_cyc.push_back(cyc); rd_addr.push_back(be_if.addr);
        end else begin
          wr_cyc.push_back(cyc); wr_addr.push_back(be_if.addr);
          wr_data.push_back(be_if.wdata); wr_strb.push_back(be_if.wstrb);
        end
      end
      if (buf_if.rvalid) begin
        rv_cyc.push_back(cyc); rv_data.push_back(buf_if.rdata);
      end
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    rd_cyc.delete(); rd_addr.delete(); rv_cyc.delete(); rv_data.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_strb.delete();
  endtask

  // Present one request for one cycle; t0 is the accept cycle (cycle 0).
  task automatic req(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [15:0] s,
                     output int t0);
    buf_if.avalid = 1'b1; buf_if.addr = a; buf_if.wdata = d; buf_if.wstrb = s;
    t0 = cyc;
    step();
    buf_if.avalid = 1'b0; buf_if.wdata = '0; buf_if.wstrb = '0;
  endtask

  task automatic wait_ready(input string tag, output int tr);
    int n;
    n = 0;
    while (!buf_if.ready && n < 200) begin step(); n++; end
    chk({tag, " ready"}, LW'(buf_if.ready), 1);
    tr = cyc;
  endtask

  localparam logic [LW-1:0] WB_LINE = 128'h44444444_33333333_22222222_11111111;
  localparam logic [LW-1:0] RF_LINE = 128'h000000A3_000000A2_000000A1_000000A0;

  initial begin
    int t0, tr, n;
    int exp_rd[4];
    int exp_rv;
    logic [DW-1:0] wv;
    cke = 1'b1; arst_n = 1'b0;
    buf_if.avalid = 1'b0; buf_if.addr = '0; buf_if.wdata = '0; buf_if.wstrb = '0;
    be_if.ready = 1'b1; be_if.rvalid = 1'b0; be_if.rdata = '0;
    step(); step();
    chk("rst ready",  LW'(buf_if.ready),  1);
    chk("rst avalid", LW'(be_if.avalid),  0);
    chk("rst rvalid", LW'(buf_if.rvalid), 0);
    chk("rst rdata",  buf_if.rdata,       0);
    arst_n = 1'b1;
    step();

    // Full write-back, back end always ready
    clr();
    req(28'h10, WB_LINE, 16'hFFFF, t0);
    wait_ready("wb", tr);
    chk("wb ready cyc", LW'(tr - t0), 5);
    chk("wb count", LW'(wr_cyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      wv = WB_LINE[i*32 +: 32];
      chk($sformatf("wb%0d cyc", i),  LW'(wr_cyc[i] - t0), LW'(i + 1));
      chk($sformatf("wb%0d addr", i), LW'(wr_addr[i]), LW'(32'h40 + i));
      chk($sformatf("wb%0d data", i), LW'(wr_data[i]), LW'(wv));
      chk($sformatf("wb%0d strb", i), LW'(wr_strb[i]), 4'hF);
    end
    chk("wb no rvalid", LW'(rv_cyc.size()), 0);

    // Partial write-back: only word 2, strobe 0x3
    clr();
    req(28'h11, WB_LINE, 16'h0300, t0);
    wait_ready("pwb", tr);
    chk("pwb count", LW'(wr_cyc.size()), 1);
    chk("pwb addr",  LW'(wr_addr[0]), 30'h46);
    chk("pwb data",  LW'(wr_data[0]), 32'h33333333);
    chk("pwb strb",  LW'(wr_strb[0]), 4'h3);
    chk("pwb ready cyc", LW'(tr - t0), 2);

    // Refill, 2-cycle latency
    clr(); lat = 2;
`ifdef IOB_CACHE_LINE_FILL_PIPELINE_EN
    exp_rv = 7;
`else
    exp_rv = 13;
`endif
    req(28'h20, '0, 16'h0000, t0);
    wait_ready("rf", tr);
    step(); step(); step();
    chk("rf pulses", LW'(rv_cyc.size()), 1);
    chk("rf data", rv_data[0], RF_LINE);
    chk("rf rvalid cyc", LW'(rv_cyc[0] - t0), LW'(exp_rv));
    chk("rf ready cyc", LW'(tr - t0), LW'(exp_rv + 1));
    chk("rf reads", LW'(rd_cyc.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rf rd%0d addr", i), LW'(rd_addr[i]), LW'(32'h80 + i));
    chk("rf rdata hold", buf_if.rdata, RF_LINE);

    // Back-end stall of 5 cycles on word 1
    clr();
    req(28'h30, WB_LINE, 16'hFFFF, t0);
    step();
    be_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d bus", k), {be_if.avalid, be_if.addr, be_if.wdata, be_if.wstrb},
          {1'b1, 30'hC1, 32'h22222222, 4'hF});
      step();
    end
    be_if.ready = 1'b1;
    wait_ready("stall", tr);
    chk("stall count", LW'(wr_cyc.size()), 4);
    chk("stall w1 addr", LW'(wr_addr[1]), 30'hC1);
    chk("stall w2 addr", LW'(wr_addr[2]), 30'hC2);
    chk("stall ready cyc", LW'(tr - t0), 10);
    chk("wb keeps rdata", buf_if.rdata, RF_LINE);

    // Reset while word 2 of a refill is on the bus
    clr(); lat = 2;
    req(28'h21, '0, 16'h0000, t0);
    n = 0;
    while (!(be_if.avalid && be_if.addr[1:0] == 2'd2) && n < 50) begin step(); n++; end
    chk("mid word2 seen", LW'(be_if.avalid && be_if.addr[1:0] == 2'd2), 1);
    arst_n = 1'b0;
    #1;
    chk("mid ready",  LW'(buf_if.ready),  1);
    chk("mid avalid", LW'(be_if.avalid),  0);
    chk("mid rvalid", LW'(buf_if.rvalid), 0);
    chk("mid rdata",  buf_if.rdata,       0);
    step();
    arst_n = 1'b1;
    step();
    clr();
    req(28'h22, '0, 16'h0000, t0);
    wait_ready("post", tr);
    chk("post pulses", LW'(rv_cyc.size()), 1);
    chk("post data", rv_data[0], RF_LINE);
    chk("post rdata", buf_if.rdata, RF_LINE);

    // Refill with 3-cycle latency: read issue timing
    clr(); lat = 3;
`ifdef IOB_CACHE_LINE_FILL_PIPELINE_EN
    exp_rd = '{1, 2, 3, 4}; exp_rv = 8;
`else
    exp_rd = '{1, 5, 9, 13}; exp_rv = 17;
`endif
    req(28'h23, '0, 16'h0000, t0);
    wait_ready("l3", tr);
    chk("l3 reads", LW'(rd_cyc.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("l3 rd%0d cyc", i), LW'(rd_cyc[i] - t0), LW'(exp_rd[i]));
    chk("l3 rvalid cyc", LW'(rv_cyc[0] - t0), LW'(exp_rv));
    chk("l3 data", rv_data[0], RF_LINE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
